// File: rtl/mem_wb_skid.sv
// MEM/WB pipeline register with valid/ready handshake and a 2-entry skid buffer.
// in_ready is decoded from registered state only, so stalls never form a combinational ready path.
module mem_wb_skid #(
   parameter int XLEN             = 32,
   parameter int RD_W             = 5,
   parameter int RS_W             = 2,
   parameter bit ZERO_RD_SUPPRESS = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            RegWriteM,
   input  logic [RS_W-1:0] ResultSrcM,
   input  logic [XLEN-1:0] ALUResultM,
   input  logic [XLEN-1:0] ReadDataM,
   input  logic [RD_W-1:0] RdM,
   input  logic [XLEN-1:0] PCPlus4M,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            RegWriteW,
   output logic [RS_W-1:0] ResultSrcW,
   output logic [XLEN-1:0] ALUResultW,
   output logic [XLEN-1:0] ReadDataW,
   output logic [RD_W-1:0] RdW,
   output logic [XLEN-1:0] PCPlus4W,
   output logic [1:0]      count
);

   typedef struct packed {
      logic            rw;
      logic [RS_W-1:0] rs;
      logic [XLEN-1:0] alu;
      logic [XLEN-1:0] rdata;
      logic [RD_W-1:0] rd;
      logic [XLEN-1:0] pc;
   } wb_pld_t;

   wb_pld_t main_q, main_d, skid_q, skid_d, in_pld;
   logic    main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
   logic    accept, pop;

   assign in_pld   = '{rw: RegWriteM, rs: ResultSrcM, alu: ALUResultM,
                       rdata: ReadDataM, rd: RdM, pc: PCPlus4M};
   assign in_ready = ~skid_vld_q & ~rst;
   assign accept   = in_valid & in_ready;
   assign pop      = main_vld_q & out_ready;

   always_comb begin
      main_d     = main_q;
      skid_d     = skid_q;
      main_vld_d = main_vld_q;
      skid_vld_d = skid_vld_q;
      if (flush) begin
         // Payload is left untouched so the W outputs keep showing the last bundle.
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else begin
         case ({main_vld_q, skid_vld_q})
            2'b00: begin
               if (accept) begin
                  main_d     = in_pld;
                  main_vld_d = 1'b1;
               end
            end
            2'b10: begin
               if (accept && pop) begin
                  main_d = in_pld;
               end else if (accept) begin
                  skid_d     = in_pld;
                  skid_vld_d = 1'b1;
               end else if (pop) begin
                  main_vld_d = 1'b0;
               end
            end
            2'b11: begin
               if (pop) begin
                  main_d     = skid_q;
                  skid_vld_d = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_q     <= '0;
         skid_q     <= '0;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
      end
   end

   assign out_valid  = main_vld_q;
   assign count      = {1'b0, main_vld_q} + {1'b0, skid_vld_q};
   assign RegWriteW  = main_q.rw & main_vld_q & (~ZERO_RD_SUPPRESS | (|main_q.rd));
   assign ResultSrcW = main_q.rs;
   assign ALUResultW = main_q.alu;
   assign ReadDataW  = main_q.rdata;
   assign RdW        = main_q.rd;
   assign PCPlus4W   = main_q.pc;

endmodule

// File: tb/tb_mem_wb_skid.sv
// Bench for mem_wb_skid: queue-based occupancy model checked every cycle plus directed literal checks.
module tb_mem_wb_skid;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic        RegWriteM;
   logic [1:0]  ResultSrcM;
   logic [31:0] ALUResultM, ReadDataM, PCPlus4M;
   logic [4:0]  RdM;

   logic        in_ready, out_valid, RegWriteW;
   logic [1:0]  ResultSrcW, count;
   logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
   logic [4:0]  RdW;

   logic        n_in_ready, n_out_valid, n_RegWriteW;
   logic [1:0]  n_ResultSrcW, n_count;
   logic [31:0] n_ALUResultW, n_ReadDataW, n_PCPlus4W;
   logic [4:0]  n_RdW;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_wb_skid #(.ZERO_RD_SUPPRESS(1'b1)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM),
      .ReadDataM(ReadDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
      .out_valid(out_valid), .out_ready(out_ready), .RegWriteW(RegWriteW),
      .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
      .RdW(RdW), .PCPlus4W(PCPlus4W), .count(count));

   mem_wb_skid #(.ZERO_RD_SUPPRESS(1'b0)) dut_ns (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
      .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM),
      .ReadDataM(ReadDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
      .out_valid(n_out_valid), .out_ready(out_ready), .RegWriteW(n_RegWriteW),
      .ResultSrcW(n_ResultSrcW), .ALUResultW(n_ALUResultW), .ReadDataW(n_ReadDataW),
      .RdW(n_RdW), .PCPlus4W(n_PCPlus4W), .count(n_count));

   typedef struct packed {
      logic        rw;
      logic [1:0]  rs;
      logic [31:0] alu;
      logic [31:0] rdata;
      logic [4:0]  rd;
      logic [31:0] pc;
   } bnd_t;

   bnd_t q[$];
   bnd_t shown;
   logic mdl_ok = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Model: an ordered FIFO of at most two bundles; the head is what W shows.
   task automatic model_step();
      bnd_t inb;
      logic acc, pp;
      inb = '{rw: RegWriteM, rs: ResultSrcM, alu: ALUResultM, rdata: ReadDataM,
              rd: RdM, pc: PCPlus4M};
      acc = in_valid && (q.size() < 2);
      pp  = (q.size() > 0) && out_ready;
      if (rst) begin
         q.delete();
         shown  = '0;
         mdl_ok = 1'b1;
      end else if (flush) begin
         q.delete();
      end else begin
         if (pp) void'(q.pop_front());
         if (acc) q.push_back(inb);
      end
      if (q.size() > 0) shown = q[0];
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (mdl_ok) begin
         chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
         chk("count", {30'b0, count}, q.size());
         chk("in_ready", {31'b0, in_ready}, {31'b0, !rst && q.size() < 2});
         chk("RegWriteW", {31'b0, RegWriteW},
             {31'b0, q.size() > 0 && shown.rw && shown.rd != 5'd0});
         chk("RegWriteW_nosup", {31'b0, n_RegWriteW}, {31'b0, q.size() > 0 && shown.rw});
         chk("ResultSrcW", {30'b0, ResultSrcW}, {30'b0, shown.rs});
         chk("ALUResultW", ALUResultW, shown.alu);
         chk("ReadDataW", ReadDataW, shown.rdata);
         chk("RdW", {27'b0, RdW}, {27'b0, shown.rd});
         chk("PCPlus4W", PCPlus4W, shown.pc);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic v, input logic [4:0] rd, input logic [31:0] alu,
                         input logic rw);
      in_valid   = v;
      RdM        = rd;
      ALUResultM = alu;
      RegWriteM  = rw;
      ReadDataM  = alu ^ 32'h5A5A_0000;
      PCPlus4M   = 32'h1000 + {25'b0, rd, 2'b00};
      ResultSrcM = rd[1:0];
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
      set_in(1'b0, 5'd0, 32'h0, 1'b0);
      #1 chk("lit_in_ready_rst", {31'b0, in_ready}, 32'd0);
      cyc(); cyc();
      chk("lit_rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("lit_rst_count", {30'b0, count}, 32'd0);
      chk("lit_rst_ALU", ALUResultW, 32'd0);
      rst = 1'b0;
      set_in(1'b1, 5'd1, 32'h10, 1'b1);
      #1 chk("lit_in_ready_post_rst", {31'b0, in_ready}, 32'd1);

      // Streaming at full rate
      for (int i = 1; i <= 4; i++) begin
         cyc();
         chk("lit_stream_RdW", {27'b0, RdW}, i);
         chk("lit_stream_count", {30'b0, count}, 32'd1);
         chk("lit_stream_in_ready", {31'b0, in_ready}, 32'd1);
         if (i < 4) set_in(1'b1, 5'(i + 1), 32'h10 + i, 1'b1);
         else       set_in(1'b0, 5'd0, 32'h0, 1'b0);
      end
      cyc();
      chk("lit_stream_drain", {30'b0, count}, 32'd0);
      chk("lit_stream_hold_RdW", {27'b0, RdW}, 32'd4);

      // Backpressure fills the skid entry
      out_ready = 1'b0;
      set_in(1'b1, 5'd5, 32'h20, 1'b1); cyc();
      chk("lit_bp_count1", {30'b0, count}, 32'd1);
      set_in(1'b1, 5'd6, 32'h21, 1'b1); cyc();
      chk("lit_bp_count2", {30'b0, count}, 32'd2);
      chk("lit_bp_in_ready", {31'b0, in_ready}, 32'd0);
      set_in(1'b1, 5'd7, 32'h22, 1'b1); cyc();
      chk("lit_bp_RdW5", {27'b0, RdW}, 32'd5);
      out_ready = 1'b1; cyc();
      chk("lit_bp_RdW6", {27'b0, RdW}, 32'd6);
      cyc();
      chk("lit_bp_RdW7", {27'b0, RdW}, 32'd7);
      set_in(1'b0, 5'd0, 32'h0, 1'b0); cyc();
      chk("lit_bp_empty", {30'b0, count}, 32'd0);

      // Write to x0
      out_ready = 1'b0;
      set_in(1'b1, 5'd0, 32'hDEAD, 1'b1); cyc();
      set_in(1'b0, 5'd0, 32'h0, 1'b0);
      chk("lit_x0_valid", {31'b0, out_valid}, 32'd1);
      chk("lit_x0_ALU", ALUResultW, 32'hDEAD);
      chk("lit_x0_RegWriteW", {31'b0, RegWriteW}, 32'd0);
      chk("lit_x0_RegWriteW_nosup", {31'b0, n_RegWriteW}, 32'd1);
      out_ready = 1'b1; cyc();

      // Flush from FULL with an offered bundle
      out_ready = 1'b0;
      set_in(1'b1, 5'd8, 32'h30, 1'b1); cyc();
      set_in(1'b1, 5'd10, 32'h31, 1'b1); cyc();
      chk("lit_fl_count2", {30'b0, count}, 32'd2);
      set_in(1'b1, 5'd9, 32'h32, 1'b1); flush = 1'b1; cyc();
      flush = 1'b0; set_in(1'b0, 5'd0, 32'h0, 1'b0);
      chk("lit_fl_out_valid", {31'b0, out_valid}, 32'd0);
      chk("lit_fl_count", {30'b0, count}, 32'd0);
      chk("lit_fl_in_ready", {31'b0, in_ready}, 32'd1);
      chk("lit_fl_RegWriteW", {31'b0, RegWriteW}, 32'd0);
      chk("lit_fl_hold_RdW", {27'b0, RdW}, 32'd8);
      // Flush from ONE while in_ready=1: offered bundle is dropped
      set_in(1'b1, 5'd11, 32'h33, 1'b1); cyc();
      set_in(1'b1, 5'd12, 32'h34, 1'b1); flush = 1'b1; cyc();
      flush = 1'b0; set_in(1'b0, 5'd0, 32'h0, 1'b0);
      chk("lit_fl1_count", {30'b0, count}, 32'd0);
      chk("lit_fl1_hold_RdW", {27'b0, RdW}, 32'd11);
      out_ready = 1'b1; cyc(); cyc();
      chk("lit_fl1_nothing", {31'b0, out_valid}, 32'd0);

      // Reset while full
      out_ready = 1'b0;
      set_in(1'b1, 5'd13, 32'h50, 1'b1); cyc();
      set_in(1'b1, 5'd14, 32'h51, 1'b1); cyc();
      chk("lit_mr_count2", {30'b0, count}, 32'd2);
      set_in(1'b0, 5'd0, 32'h0, 1'b0); rst = 1'b1;
      #1 chk("lit_mr_in_ready_rst", {31'b0, in_ready}, 32'd0);
      cyc();
      rst = 1'b0;
      #1;
      chk("lit_mr_count", {30'b0, count}, 32'd0);
      chk("lit_mr_valid", {31'b0, out_valid}, 32'd0);
      chk("lit_mr_RdW", {27'b0, RdW}, 32'd0);
      chk("lit_mr_PC", PCPlus4W, 32'd0);
      chk("lit_mr_in_ready", {31'b0, in_ready}, 32'd1);

      // Accept and pop together in ONE
      out_ready = 1'b1;
      set_in(1'b1, 5'd3, 32'h40, 1'b1); cyc();
      chk("lit_ap_RdW3", {27'b0, RdW}, 32'd3);
      set_in(1'b1, 5'd4, 32'h41, 1'b1); cyc();
      chk("lit_ap_RdW4", {27'b0, RdW}, 32'd4);
      chk("lit_ap_count", {30'b0, count}, 32'd1);
      chk("lit_ap_ALU", ALUResultW, 32'h41);
      set_in(1'b0, 5'd0, 32'h0, 1'b0); cyc();
      chk("lit_ap_empty", {30'b0, count}, 32'd0);
      cyc(); cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_wb_skid.md
Name: mem_wb_skid

Overview:
- Parametrised successor to the fixed MEM/WB pipeline register.
- Carries the memory-stage result bundle to writeback: RegWrite, ResultSrc, ALUResult, ReadData, Rd and PCPlus4.
- Adds a valid/ready handshake, a 2-entry skid buffer so stalls do not need a combinational ready path, flush (bubble insertion), and optional x0 write suppression.
- Sits between the MEM stage and the writeback mux/register file.

Parameters:
- XLEN, 32, width of ALUResult, ReadData and PCPlus4.
- RD_W, 5, destination register index width.
- RS_W, 2, ResultSrc select width.
- ZERO_RD_SUPPRESS, 1, when 1, RegWriteW is forced to 0 whenever RdW is 0.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- flush  input  1  discard all held entries.
- in_valid  input  1  MEM bundle valid.
- in_ready  output  1  block can accept a bundle this cycle.
- RegWriteM  input  1  register write enable.
- ResultSrcM  input  RS_W  writeback source select.
- ALUResultM  input  XLEN  ALU result.
- ReadDataM  input  XLEN  load data.
- RdM  input  RD_W  destination register.
- PCPlus4M  input  XLEN  return address.
- out_valid  output  1  W bundle valid.
- out_ready  input  1  writeback consumes the bundle.
- RegWriteW  output  1  gated write enable.
- ResultSrcW  output  RS_W  writeback source select.
- ALUResultW  output  XLEN  ALU result.
- ReadDataW  output  XLEN  load data.
- RdW  output  RD_W  destination register.
- PCPlus4W  output  XLEN  return address.
- count  output  2  number of occupied entries (0..2).

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Storage: a main entry (drives the W outputs) and a skid entry, each with a valid bit and a full payload copy.
- Definitions: accept = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = ~skid_valid & ~rst. It is decoded only from registered state and never depends on out_ready.
- out_valid = main_valid.
- count = main_valid + skid_valid.
- Occupancy states and transitions:
  - EMPTY: accept -> main<=in, go to ONE.
  - ONE, accept & pop -> main<=in, stay in ONE.
  - ONE, accept & ~pop -> skid<=in, go to FULL.
  - ONE, ~accept & pop -> go to EMPTY.
  - ONE, otherwise -> hold.
  - FULL: in_ready=0. pop -> main<=skid, skid_valid<=0, go to ONE. Otherwise hold.
- Ordering: bundles leave in arrival order. No bundle is dropped or duplicated except by flush or rst.
- Latency: 1 cycle from accept into EMPTY to out_valid=1.
- Throughput: 1 bundle/cycle when out_ready is held at 1.
- RegWriteW = main_RegWrite & main_valid, additionally & (RdW != 0) when ZERO_RD_SUPPRESS=1.
- Other W payload outputs show the main payload registers. They hold their last value when main_valid=0.
- Reset (rst=1): on the next edge main_valid, skid_valid and every payload register go to 0. So after reset: out_valid=0, RegWriteW=0, ResultSrcW=0, ALUResultW=0, ReadDataW=0, RdW=0, PCPlus4W=0, count=0. in_ready=0 while rst is high and 1 on the first cycle after.
- Flush (rst=0, flush=1): on the next edge main_valid and skid_valid go to 0.
  - A bundle offered in the same cycle is discarded, even though in_ready may be 1.
  - Payload registers are not modified.
  - flush takes priority over accept and pop.
- Reset in the middle of operation (any state) behaves exactly as from idle. rst takes priority over flush.
- No width arithmetic. The payload is transferred bit-exact.

Test Plan:
- Reset then stream: rst for 2 cycles, then 4 bundles (Rd=1..4, ALUResult=0x10..0x13, RegWrite=1) with out_ready=1 -> out_valid rises 1 cycle after the first accept, RdW=1,2,3,4 on consecutive cycles, count stays at 1, in_ready stays 1.
- Backpressure: out_ready=0 while 3 bundles are offered (Rd=5,6,7) -> first two accepted, count=2, in_ready=0, Rd=7 held by the source. Then out_ready=1 -> RdW=5, 6, 7 in order with no loss.
- x0 suppression: bundle Rd=0, RegWrite=1, ALUResult=0xDEAD -> out_valid=1, ALUResultW=0xDEAD, RegWriteW=0. With ZERO_RD_SUPPRESS=0 -> RegWriteW=1.
- Flush: count=2 and in_valid=1 (Rd=9) with flush=1 -> next cycle out_valid=0, count=0, in_ready=1, RegWriteW=0. Rd=9 never appears.
- Reset mid-operation: count=2 with out_ready=0, then rst=1 for 1 cycle -> next cycle all outputs 0, count=0. in_ready=0 during rst and 1 after.
- Simultaneous accept and pop in ONE: main holds Rd=3, in_valid=1 (Rd=4), out_ready=1 -> next cycle RdW=4, count=1, skid unused.
